// File: rtl/clk_util_pkg.sv
// Shared clocking-utility definitions: meter FSM states and synchronizer/warm-up constants.
package clk_util_pkg;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    IDLE  = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } meter_state_e;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned WARMUP_CYCLES = 3;

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous input into the clk_in domain and flags its rising edges.
module sync_rise_detect
  import clk_util_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  // chain[SYNC_STAGES-1] is the synchronized level, chain[SYNC_STAGES] its one-cycle delay
  logic [SYNC_STAGES:0] chain;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-1:0], sig_in};
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];

endmodule

// File: rtl/clk_freq_meter.sv
// Counts sig_in rising edges over a gate window of PARAM_GATE_CYCLES clk_in cycles.
module clk_freq_meter
  import clk_util_pkg::*;
#(
  parameter int unsigned PARAM_INPUT_FREQ  = 100000000,
  parameter int unsigned PARAM_GATE_CYCLES = 100000000,
  parameter int unsigned PARAM_COUNT_WIDTH = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         sig_in,
  input  logic                         start,
  input  logic                         continuous,
  output logic [PARAM_COUNT_WIDTH-1:0] freq_out,
  output logic                         freq_valid,
  output logic                         busy,
  output logic                         overflow
);

  localparam int unsigned CW     = PARAM_COUNT_WIDTH;
  localparam int unsigned GATE_W = $clog2(PARAM_GATE_CYCLES);
  localparam int unsigned WARM_W = $clog2(WARMUP_CYCLES + 1);
  localparam logic [GATE_W-1:0] LAST_GATE = GATE_W'(PARAM_GATE_CYCLES - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES);

  if (PARAM_GATE_CYCLES < 2) begin : g_gate_check
    $error("clk_freq_meter: PARAM_GATE_CYCLES must be at least 2");
  end
  if (PARAM_INPUT_FREQ == 0) begin : g_freq_check
    $error("clk_freq_meter: PARAM_INPUT_FREQ must be non-zero");
  end

  meter_state_e      state, state_next;
  logic [WARM_W-1:0] warm_cnt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CW-1:0]     edge_cnt;
  logic              overflow_acc;
  logic              rise;
  logic              enter_gate_c;

  sync_rise_detect u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= WARM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    enter_gate_c = 1'b0;
    unique case (state)
      WARM:    if (warm_cnt == WARM_LAST) state_next = IDLE;
      IDLE:    if (start) state_next = GATE;
      GATE:    if (gate_cnt == LAST_GATE) state_next = LATCH;
      LATCH:   state_next = continuous ? GATE : IDLE;
      default: state_next = WARM;
    endcase
    enter_gate_c = (state_next == GATE) && (state != GATE);
  end

  // Counters and result registers; edges seen in IDLE/LATCH fall outside any window
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt     <= '0;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      overflow_acc <= 1'b0;
      freq_out     <= '0;
      freq_valid   <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b1;
    end else begin
      freq_valid <= 1'b0;
      busy       <= (state_next != IDLE);

      if (state == WARM && warm_cnt != WARM_LAST) begin
        warm_cnt <= warm_cnt + WARM_W'(1);
      end

      if (enter_gate_c) begin
        gate_cnt     <= '0;
        edge_cnt     <= '0;
        overflow_acc <= 1'b0;
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        if (rise) begin
          if (&edge_cnt) begin
            overflow_acc <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + CW'(1);
          end
        end
      end

      if (state == LATCH) begin
        freq_out   <= edge_cnt;
        overflow   <= overflow_acc;
        freq_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Randomized bench for clk_freq_meter: two widths driven in parallel against a window-level model.
module tb_clk_freq_meter;

  localparam int unsigned G = 100;

  logic        clk_in;
  logic        rst_n;
  logic        sig_in;
  logic        start;
  logic        continuous;
  logic [31:0] f32;
  logic        valid32, busy32, ovf32;
  logic [3:0]  f4;
  logic        valid4, busy4, ovf4;

  clk_freq_meter #(
    .PARAM_INPUT_FREQ (100000000),
    .PARAM_GATE_CYCLES(G),
    .PARAM_COUNT_WIDTH(32)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .continuous(continuous),
    .freq_out  (f32),
    .freq_valid(valid32),
    .busy      (busy32),
    .overflow  (ovf32)
  );

  clk_freq_meter #(
    .PARAM_INPUT_FREQ (100000000),
    .PARAM_GATE_CYCLES(G),
    .PARAM_COUNT_WIDTH(4)
  ) dut4 (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .continuous(continuous),
    .freq_out  (f4),
    .freq_valid(valid4),
    .busy      (busy4),
    .overflow  (ovf4)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // sig_in generator: programmable high/low lengths, optional random lengths and phase jitter
  int   hi_len   = 5;
  int   lo_len   = 5;
  bit   rnd_mode = 0;
  bit   hold_en  = 0;
  bit   hold_val = 0;
  initial begin
    int cnt;
    cnt    = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rnd_mode) #($urandom_range(0, 3));
      if (hold_en) begin
        sig_in = hold_val;
        cnt    = 0;
      end else begin
        cnt++;
        if (cnt >= (sig_in ? hi_len : lo_len)) begin
          sig_in = ~sig_in;
          cnt    = 0;
          if (rnd_mode) begin
            hi_len = $urandom_range(2, 7);
            lo_len = $urandom_range(2, 7);
          end
        end
      end
    end
  end

  // Window-level model: e_idx counts clk edges since reset release; a rise is seen
  // two edges after sampling and a window started at edge t0 counts edges t0+1..t0+G.
  int unsigned e_idx     = 0;
  int unsigned t0        = 0;
  int unsigned acc       = 0;
  bit          in_win    = 0;
  bit          h1 = 0, h2 = 0, h3 = 0;
  bit          rise_now  = 0;
  bit          exp_valid = 0;
  bit          exp_busy  = 1;
  int unsigned exp_cnt   = 0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      e_idx = 0; in_win = 0; acc = 0;
      h1 = 0; h2 = 0; h3 = 0;
      exp_valid = 0; exp_busy = 1; exp_cnt = 0;
    end else begin
      e_idx++;
      rise_now = h2 && !h3;
      h3 = h2; h2 = h1; h1 = sig_in;
      exp_valid = 0;
      if (in_win && e_idx <= t0 + G && rise_now) acc++;
      if (in_win && e_idx == t0 + G + 1) begin
        exp_valid = 1;
        exp_cnt   = acc;
        if (continuous) begin
          t0 = e_idx; acc = 0;
        end else begin
          in_win = 0;
        end
      end else if (!in_win && e_idx >= 5 && start) begin
        in_win = 1; t0 = e_idx; acc = 0;
      end
      exp_busy = (e_idx < 4) || in_win;
    end
  end

  always @(negedge clk_in) begin
    check("busy",        32'(busy32),  32'(exp_busy));
    check("busy_w4",     32'(busy4),   32'(exp_busy));
    check("valid",       32'(valid32), 32'(exp_valid));
    check("valid_w4",    32'(valid4),  32'(exp_valid));
    check("freq_out",    f32,          exp_cnt);
    check("freq_out_w4", 32'(f4),      (exp_cnt > 15) ? 32'd15 : exp_cnt);
    check("overflow",    32'(ovf32),   32'd0);
    check("overflow_w4", 32'(ovf4),    (exp_cnt > 15) ? 32'd1 : 32'd0);
    if (valid32) n_valid++;
  end

  int unsigned s_edge;

  task automatic pulse_start();
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start  = 1'b0;
    s_edge = e_idx;
  endtask

  task automatic wait_valid(input int budget, output int unsigned edge_at);
    bit found;
    found   = 0;
    edge_at = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_in);
      if (valid32) begin
        found   = 1;
        edge_at = e_idx;
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL wait_valid: no freq_valid within %0d cycles at %0t", budget, $time);
    end
  endtask

  // Busy must hold through three edges after release and drop on the fourth
  task automatic warm_check(input string tag);
    repeat (3) @(posedge clk_in);
    #1 check({tag, "_busy_e3"}, 32'(busy32), 32'd1);
    start = 1'b0;
    @(posedge clk_in);
    #1 check({tag, "_busy_e4"}, 32'(busy32), 32'd0);
    check({tag, "_valid_e4"}, 32'(valid32), 32'd0);
    check({tag, "_freq_e4"}, f32, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v1, v2, v3, v4, v5;
    int nv;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
    repeat (3) @(negedge clk_in);
    #2 rst_n = 1'b1;
    start = 1'b1;
    warm_check("warm");
    repeat (150) @(negedge clk_in);
    check("warm_start_ignored", 32'(n_valid), 32'd0);

    // single window, period 10
    pulse_start();
    nv = n_valid;
    wait_valid(200, v1);
    check("single_latency_edges", v1 - s_edge, G + 1);
    check("single_freq", f32, 32'd10);
    check("single_model", exp_cnt, 32'd10);
    check("single_ovf", 32'(ovf32), 32'd0);
    check("single_freq_w4", 32'(f4), 32'd10);
    repeat (50) @(negedge clk_in);
    check("single_one_pulse", 32'(n_valid - nv), 32'd1);
    check("single_busy_low", 32'(busy32), 32'd0);

    // continuous, period 4 then 20; 4-bit instance saturates
    hi_len = 2; lo_len = 2;
    continuous = 1'b1;
    repeat (10) @(negedge clk_in);
    pulse_start();
    wait_valid(200, v1);
    check("cont_first_range", 32'(f32 >= 24 && f32 <= 26), 32'd1);
    wait_valid(200, v2);
    check("cont_period_edges", v2 - v1, G + 1);
    check("cont_freq", f32, 32'd25);
    check("ovf_freq_w4", 32'(f4), 32'd15);
    check("ovf_flag_w4", 32'(ovf4), 32'd1);
    hi_len = 10; lo_len = 10;
    wait_valid(200, v3);
    wait_valid(200, v4);
    check("cont_period2_edges", v4 - v3, G + 1);
    check("slow_freq", f32, 32'd5);
    check("slow_freq_w4", 32'(f4), 32'd5);
    check("slow_ovf_w4", 32'(ovf4), 32'd0);
    repeat (40) @(negedge clk_in);
    continuous = 1'b0;
    wait_valid(200, v5);
    repeat (5) @(negedge clk_in);
    check("cont_drop_busy", 32'(busy32), 32'd0);
    nv = n_valid;
    repeat (150) @(negedge clk_in);
    check("cont_drop_no_more", 32'(n_valid - nv), 32'd0);

    // start during GATE is ignored
    hi_len = 5; lo_len = 5;
    repeat (10) @(negedge clk_in);
    nv = n_valid;
    pulse_start();
    repeat (30) @(negedge clk_in);
    pulse_start();
    wait_valid(200, v1);
    check("gate_start_freq", f32, 32'd10);
    repeat (150) @(negedge clk_in);
    check("gate_start_single", 32'(n_valid - nv), 32'd1);

    // reset at gate cycle ~50 aborts with no result
    pulse_start();
    repeat (49) @(negedge clk_in);
    #2 rst_n = 1'b0;
    nv = n_valid;
    @(negedge clk_in);
    check("abort_freq", f32, 32'd0);
    check("abort_valid", 32'(valid32), 32'd0);
    check("abort_busy", 32'(busy32), 32'd1);
    @(negedge clk_in);
    #2 rst_n = 1'b1;
    warm_check("rewarm");
    repeat (200) @(negedge clk_in);
    check("abort_no_valid", 32'(n_valid - nv), 32'd0);

    // idle input held high, then low
    hold_en = 1; hold_val = 1;
    repeat (10) @(negedge clk_in);
    pulse_start();
    wait_valid(200, v1);
    check("idle_hi_freq", f32, 32'd0);
    check("idle_hi_ovf", 32'(ovf32), 32'd0);
    hold_val = 0;
    repeat (10) @(negedge clk_in);
    pulse_start();
    wait_valid(200, v1);
    check("idle_lo_freq", f32, 32'd0);
    check("idle_lo_ovf_w4", 32'(ovf4), 32'd0);
    hold_en = 0;

    // random input timing with random start/continuous traffic
    rnd_mode = 1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk_in);
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) continuous = ~continuous;
    end
    @(negedge clk_in);
    start = 1'b0;
    continuous = 1'b0;
    repeat (250) @(negedge clk_in);
    check("final_idle_busy", 32'(busy32), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_freq_meter.md
# clk_freq_meter

Measures the frequency of an external signal `sig_in` that is asynchronous to `clk_in`. It counts rising edges of `sig_in` over a fixed gate window of `PARAM_GATE_CYCLES` clock cycles, then reports the count. It is the measuring counterpart of the clock dividers: dividers generate a known frequency from `clk_in`, and this block recovers an unknown frequency against `clk_in`. With the default gate of one second at 100 MHz, `freq_out` reads directly in Hz.

## Interface
- `PARAM_INPUT_FREQ`, default 100000000: `clk_in` frequency in Hz. Documentation and sanity check only.
- `PARAM_GATE_CYCLES`, default 100000000: gate window length in `clk_in` cycles. Must be ≥ 2; elaboration error otherwise.
- `PARAM_COUNT_WIDTH`, default 32: width of the edge counter and of `freq_out`.
- `clk_in`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sig_in`  in  1  measured signal, asynchronous to `clk_in`.
- `start`  in  1  level-sampled request to begin a measurement.
- `continuous`  in  1  when 1, measurement windows repeat back-to-back.
- `freq_out`  out  `PARAM_COUNT_WIDTH`  rising-edge count of the last completed window. Held until the next window completes.
- `freq_valid`  out  1  one-cycle pulse when `freq_out` updates.
- `busy`  out  1  high during warm-up and while a measurement is in progress.
- `overflow`  out  1  the last completed window saturated the counter. Updated together with `freq_out`.

## Operation
- **Input path.** `sig_in` passes through a 2-flop synchronizer and then a 3rd delay flop. A rising edge is detected when `sync2 == 1 && sync3 == 0`. All three flops reset to 0.
- **Warm-up.** A 3-cycle warm-up follows reset release. During warm-up, `busy` = 1 and `start` is ignored. This suppresses the spurious edge seen when `sig_in` is already high at reset release.
- **FSM states:** WARM, IDLE, GATE, LATCH.
  - WARM → IDLE after 3 cycles.
  - IDLE → GATE when `start` is 1. On entry to GATE, the gate counter and edge counter clear to 0 and `overflow_acc` clears.
  - GATE: the gate counter increments each cycle, from 0 to `PARAM_GATE_CYCLES`-1. Each detected edge increments the edge counter. The edge in the final GATE cycle is counted. GATE → LATCH on the cycle where the gate counter equals `PARAM_GATE_CYCLES`-1.
  - LATCH: registers `freq_out` ← edge count and `overflow` ← `overflow_acc`, and sets `freq_valid` to 1 for the next cycle. Edges detected in LATCH are not counted (one dead cycle per window). LATCH → GATE (counters cleared) if `continuous` is 1, else LATCH → IDLE.
- **Saturation.** The edge counter stops at all-ones. An edge arriving while the counter is at all-ones sets `overflow_acc`.
- **Input bandwidth.** `sig_in` high and low times must each be ≥ 2 `clk_in` periods. Faster inputs undercount; this is not flagged.
- **Boundary behaviour:**
  - `start` during WARM, GATE or LATCH: ignored, no queuing.
  - `continuous` falling mid-window: the current window completes and reports, then the FSM goes to IDLE.
  - `continuous` = 1 with `start` = 0 in IDLE: no measurement starts. `start` is required to leave IDLE.
  - `rst_n` asserted mid-window: immediate abort. `freq_out`, `overflow` and `freq_valid` go to 0 and no partial result is reported.
- **Widths.** Gate counter width is `$clog2(PARAM_GATE_CYCLES)`. Frequency in Hz = `freq_out` × `PARAM_INPUT_FREQ` / `PARAM_GATE_CYCLES`; this conversion is not computed in hardware.

## Timing
- **Reset values:** `freq_out` = 0, `freq_valid` = 0, `overflow` = 0, `busy` = 1 (warm-up), FSM = WARM.
- **Warm-up:** `busy` falls to 0 at the 4th rising edge of `clk_in` after `rst_n` deasserts.
- **Single measurement,** with `start` sampled high in IDLE at edge t:
  - `busy` = 1 from t+1 through the LATCH cycle.
  - GATE occupies cycles t+1 … t+`PARAM_GATE_CYCLES`.
  - LATCH is at t+`PARAM_GATE_CYCLES`+1.
  - `freq_valid` = 1 and `freq_out` are updated at t+`PARAM_GATE_CYCLES`+2.
  - `busy` = 0 at t+`PARAM_GATE_CYCLES`+2.
- **Continuous mode:** one result every `PARAM_GATE_CYCLES`+1 cycles, and `busy` stays 1.
- **Edge latency:** a `sig_in` rise is counted 2–3 clocks after it occurs. A rise within the last 2–3 cycles of a window is counted in the next window, or lost if the FSM goes to IDLE.

## Structure
- Shared package `clk_util_pkg` holds:
  - the FSM state typedef (`WARM`, `IDLE`, `GATE`, `LATCH`);
  - constant `SYNC_STAGES` = 2;
  - constant `WARMUP_CYCLES` = 3.
- Sub-module `sync_rise_detect`: synchronizer plus delay flop, async active-low reset, 1-bit `rise` output. It is reusable by other blocks that take asynchronous inputs.
- Top level contains the FSM, gate counter, saturating edge counter and output registers.

## Test plan
All scenarios use `PARAM_GATE_CYCLES` = 100 and `clk_in` at 100 MHz unless stated.
- **Reset:** release `rst_n` → all outputs 0; `busy` = 1 for 3 cycles, then 0. A `start` pulse during warm-up → ignored, no `freq_valid`.
- **Single window:** `sig_in` period 10 clocks (toggles every 5), one `start` → exactly one `freq_valid` pulse, 102 cycles after the `start` edge; `freq_out` = 10, `overflow` = 0.
- **Continuous:** `sig_in` period 4, `continuous` = 1, one `start` → `freq_out` = 25 (±1 permitted only on the first window) every 101 cycles. Drop `continuous` mid-window → that window still reports, then `busy` = 0.
- **Overflow:** `PARAM_COUNT_WIDTH` = 4, `sig_in` period 4 → `freq_out` = 15, `overflow` = 1. The next window at period 20 → `freq_out` = 5, `overflow` = 0.
- **Abort and ignore:** `start` pulsed during GATE → no restart, single result. `rst_n` pulsed at gate cycle 50 → outputs 0, no `freq_valid`, warm-up repeats.
- **Idle input:** `sig_in` held at 1, then at 0, over a window → `freq_out` = 0, `freq_valid` pulses, `overflow` = 0.
